// File: rtl/bpm_pkg.sv
// Shared definitions for the BPM slow-path packetiser: packet ID,
// packet-length helper and the packer FSM state encoding.
package bpm_pkg;

    localparam logic [31:0] BPM_PID = 32'h4142504d;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        CKSUM
    } state_t;

    // Header/position words + power, max pairs, cal position, power_cal, drift, checksum.
    function automatic int unsigned pkt_len(input int unsigned n_ch);
        return 6 + 3 * n_ch + (n_ch + 1) / 2;
    endfunction

endpackage

// File: rtl/event_packer_wordsel.sv
// Combinational index-to-word mux over the event snapshot. The checksum
// slot reads as zero; the top level substitutes the running checksum there.
module event_packer_wordsel
    import bpm_pkg::*;
#(
    parameter int unsigned          N_CH       = 4,
    parameter int unsigned          DATA_WIDTH = 16,
    parameter int unsigned          SF_WIDTH   = 32,
    parameter logic [SF_WIDTH-1:0]  PID        = SF_WIDTH'(BPM_PID),
    parameter int unsigned          IDX_W      = $clog2(pkt_len(N_CH))
) (
    input  logic [IDX_W-1:0]             i_idx,
    input  logic [15:0]                  i_evt_cnt,
    input  logic [DATA_WIDTH-1:0]        i_status,
    input  logic [DATA_WIDTH-1:0]        i_x,
    input  logic [DATA_WIDTH-1:0]        i_y,
    input  logic [DATA_WIDTH-1:0]        i_s,
    input  logic [DATA_WIDTH-1:0]        i_x_cal,
    input  logic [DATA_WIDTH-1:0]        i_y_cal,
    input  logic [N_CH*SF_WIDTH-1:0]     i_power,
    input  logic [N_CH*DATA_WIDTH-1:0]   i_max,
    input  logic [N_CH*SF_WIDTH-1:0]     i_power_cal,
    input  logic [N_CH*SF_WIDTH-1:0]     i_drift_gain,
    output logic [SF_WIDTH-1:0]          o_word
);

    localparam int unsigned PKT_LEN   = pkt_len(N_CH);
    localparam int unsigned N_MAXW    = (N_CH + 1) / 2;
    localparam int unsigned MAXP_W    = 2 * N_MAXW * DATA_WIDTH;
    localparam int unsigned OFF_PWR   = 4;
    localparam int unsigned OFF_MAX   = OFF_PWR + N_CH;
    localparam int unsigned OFF_CAL   = OFF_MAX + N_MAXW;
    localparam int unsigned OFF_PCAL  = OFF_CAL + 1;
    localparam int unsigned OFF_DRIFT = OFF_PCAL + N_CH;
    localparam int unsigned N_SLOT    = 2 ** IDX_W;
    localparam logic [7:0]  LEN8      = 8'(PKT_LEN);
    localparam logic [7:0]  NCH8      = 8'(N_CH);

    logic [SF_WIDTH-1:0] w_words [N_SLOT];
    logic [MAXP_W-1:0]   w_max_pad;

    // Odd channel counts get a zero channel appended so the tail pair pads low.
    assign w_max_pad = MAXP_W'(i_max);

    assign w_words[0]       = PID;
    assign w_words[1]       = SF_WIDTH'({i_status, i_evt_cnt});
    assign w_words[2]       = SF_WIDTH'({i_x, i_y});
    assign w_words[3]       = SF_WIDTH'({i_s, LEN8, NCH8});
    assign w_words[OFF_CAL] = SF_WIDTH'({i_x_cal, i_y_cal});

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign w_words[OFF_PWR + c]   = i_power[c*SF_WIDTH +: SF_WIDTH];
        assign w_words[OFF_PCAL + c]  = i_power_cal[c*SF_WIDTH +: SF_WIDTH];
        assign w_words[OFF_DRIFT + c] = i_drift_gain[c*SF_WIDTH +: SF_WIDTH];
    end

    for (genvar k = 0; k < N_MAXW; k++) begin : g_max
        assign w_words[OFF_MAX + k] = SF_WIDTH'({w_max_pad[(2*k)*DATA_WIDTH +: DATA_WIDTH],
                                                 w_max_pad[(2*k+1)*DATA_WIDTH +: DATA_WIDTH]});
    end

    for (genvar i = PKT_LEN - 1; i < N_SLOT; i++) begin : g_pad
        assign w_words[i] = '0;
    end

    assign o_word = w_words[i_idx];

endmodule

// File: rtl/event_packer.sv
// Slow-path event packetiser: snapshots one accepted event and streams it
// into the slow FIFO as a length-tagged, XOR-checksummed packet.
module event_packer
    import bpm_pkg::*;
#(
    parameter int unsigned          N_CH       = 4,
    parameter int unsigned          DATA_WIDTH = 16,
    parameter int unsigned          SF_WIDTH   = 32,
    parameter logic [SF_WIDTH-1:0]  PID        = SF_WIDTH'(BPM_PID)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pos_rdy,
    input  logic                         cal_flag,
    input  logic                         rst_evt_no,
    input  logic [DATA_WIDTH-1:0]        status,
    input  logic [DATA_WIDTH-1:0]        x,
    input  logic [DATA_WIDTH-1:0]        y,
    input  logic [DATA_WIDTH-1:0]        s,
    input  logic [DATA_WIDTH-1:0]        x_cal,
    input  logic [DATA_WIDTH-1:0]        y_cal,
    input  logic [N_CH*SF_WIDTH-1:0]     power,
    input  logic [N_CH*DATA_WIDTH-1:0]   max,
    input  logic [N_CH*SF_WIDTH-1:0]     power_cal,
    input  logic [N_CH*SF_WIDTH-1:0]     drift_gain,
    input  logic                         fifo_prog_full,
    input  logic                         fifo_full,
    output logic [SF_WIDTH-1:0]          fifo_din,
    output logic                         fifo_wr,
    output logic                         busy,
    output logic [15:0]                  evt_cnt,
    output logic [15:0]                  drop_cnt
);

    localparam int unsigned      PKT_LEN   = pkt_len(N_CH);
    localparam int unsigned      IDX_W     = $clog2(PKT_LEN);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(PKT_LEN - 2);

    state_t                    r_state, w_state_next;
    logic [IDX_W-1:0]          r_idx;
    logic [SF_WIDTH-1:0]       r_csum;
    logic                      r_busy;
    logic [15:0]               r_evt_cnt, r_drop_cnt, w_evt_next;
    logic                      w_real, w_accept, w_drop, w_wr;
    logic [SF_WIDTH-1:0]       w_word;

    logic [15:0]               r_hdr_cnt;
    logic [DATA_WIDTH-1:0]     r_status, r_x, r_y, r_s, r_x_cal, r_y_cal;
    logic [N_CH*SF_WIDTH-1:0]  r_power, r_power_cal, r_drift_gain;
    logic [N_CH*DATA_WIDTH-1:0] r_max;

    assign w_real   = pos_rdy && !cal_flag;
    assign w_accept = w_real && (r_state == IDLE) && !fifo_prog_full;
    assign w_drop   = w_real && !w_accept;
    assign w_wr     = (r_state != IDLE) && !fifo_full;

    always_comb begin
        w_evt_next = r_evt_cnt;
        if (rst_evt_no)
            w_evt_next = '0;
        else if (w_real)
            w_evt_next = r_evt_cnt + 16'd1;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_next = EMIT;
            EMIT:    if (w_wr && r_idx == LAST_DATA) w_state_next = CKSUM;
            CKSUM:   if (w_wr) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != IDLE);
        end
    end

    // Index and checksum only move on an actual write, so fifo_full stalls are lossless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx  <= '0;
            r_csum <= '0;
        end else begin
            unique case (r_state)
                IDLE: if (w_accept) begin
                    r_idx  <= '0;
                    r_csum <= '0;
                end
                EMIT: if (w_wr) begin
                    r_idx  <= r_idx + 1'b1;
                    r_csum <= r_csum ^ w_word;
                end
                CKSUM: if (w_wr) r_idx <= '0;
                default: r_idx <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_evt_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_evt_cnt <= w_evt_next;
            if (rst_evt_no)
                r_drop_cnt <= '0;
            else if (w_drop && r_drop_cnt != '1)
                r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hdr_cnt    <= '0;
            r_status     <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_s          <= '0;
            r_x_cal      <= '0;
            r_y_cal      <= '0;
            r_power      <= '0;
            r_max        <= '0;
            r_power_cal  <= '0;
            r_drift_gain <= '0;
        end else if (w_accept) begin
            r_hdr_cnt    <= w_evt_next;
            r_status     <= status;
            r_x          <= x;
            r_y          <= y;
            r_s          <= s;
            r_x_cal      <= x_cal;
            r_y_cal      <= y_cal;
            r_power      <= power;
            r_max        <= max;
            r_power_cal  <= power_cal;
            r_drift_gain <= drift_gain;
        end
    end

    event_packer_wordsel #(
        .N_CH       (N_CH),
        .DATA_WIDTH (DATA_WIDTH),
        .SF_WIDTH   (SF_WIDTH),
        .PID        (PID),
        .IDX_W      (IDX_W)
    ) u_wordsel (
        .i_idx        (r_idx),
        .i_evt_cnt    (r_hdr_cnt),
        .i_status     (r_status),
        .i_x          (r_x),
        .i_y          (r_y),
        .i_s          (r_s),
        .i_x_cal      (r_x_cal),
        .i_y_cal      (r_y_cal),
        .i_power      (r_power),
        .i_max        (r_max),
        .i_power_cal  (r_power_cal),
        .i_drift_gain (r_drift_gain),
        .o_word       (w_word)
    );

    always_comb begin
        fifo_din = '0;
        unique case (r_state)
            EMIT:    fifo_din = w_word;
            CKSUM:   fifo_din = r_csum;
            default: fifo_din = '0;
        endcase
    end

    assign fifo_wr  = w_wr;
    assign busy     = r_busy;
    assign evt_cnt  = r_evt_cnt;
    assign drop_cnt = r_drop_cnt;

endmodule
